ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_pkg.sv | 31 +++
 rtl/ps2_sync_edge.sv | 37 +++
 rtl/ps2_host_tx.sv | 248 ++++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg - shared definitions for the PS/2 host transmitter.
//   state_t        : transmitter FSM states
//   REG_DATA/STATUS: Wishbone register select values (adr_i)
//   ST_*           : bit positions within the STATUS register
//   odd_parity()   : PS/2 frame parity for a data byte
package ps2_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INHIBIT = 3'd1,
    S_REQUEST = 3'd2,
    S_SHIFT   = 3'd3,
    S_ACK     = 3'd4,
    S_RELEASE = 3'd5
  } state_t;

  localparam logic REG_DATA   = 1'b0;
  localparam logic REG_STATUS = 1'b1;

  localparam int unsigned ST_BUSY    = 0;
  localparam int unsigned ST_DONE    = 1;
  localparam int unsigned ST_NACK    = 2;
  localparam int unsigned ST_TIMEOUT = 3;
  localparam int unsigned ST_OVERRUN = 4;

  // Parity bit that makes the count of ones across data+parity odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~(^b);
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge - multi-stage synchronizer plus falling-edge detector for
// one PS/2 line. The idle line level is high, so every stage resets to 1.
//   clk_i   : system clock
//   reset_n : asynchronous active-low reset
//   din     : raw pin level
//   level   : synchronized level
//   fall    : one-cycle pulse when the synchronized level goes 1 -> 0
module ps2_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q[0] <= din;
      for (int unsigned i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign fall  = prev_q & ~sync_q[STAGES-1];

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx - Wishbone-attached PS/2 host-to-device byte transmitter.
//   clk_i, reset_n          : clock, asynchronous active-low reset
//   cyc_i, stb_i, we_i      : Wishbone cycle / strobe / write enable
//   adr_i                   : 0 = DATA, 1 = STATUS
//   sel_i, dat_i, dat_o     : byte selects, write data, read data
//   ack_o                   : single-cycle acknowledge per access
//   ps2_clk_i, ps2_data_i   : PS/2 pin levels
//   ps2_clk_oe, ps2_data_oe : 1 pulls the corresponding PS/2 line low
//   interrupt               : DONE|NACK|TIMEOUT, only when PS2_HOST_TX_IRQ_EN
//                             is defined; tied low otherwise
// STATUS: bit0 busy, bit1 DONE, bit2 NACK, bit3 TIMEOUT, bit4 OVERRUN;
// bits 4:1 are sticky and cleared by writing 1.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic        clk_i,
  input  logic        reset_n,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic        adr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  input  logic        ps2_clk_i,
  input  logic        ps2_data_i,
  output logic        ps2_clk_oe,
  output logic        ps2_data_oe,
  output logic        interrupt
);

  localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                                    INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       idx_q, idx_d;
  logic [7:0]       data_q;
  logic             parity_q;
  logic [9:0]       frame;

  logic done_q, nack_q, timeout_q, overrun_q;
  logic set_done, set_nack, set_timeout;
  logic [3:0] clr;

  logic        acked_q;
  logic [31:0] dat_q;
  logic        access, wr_data, wr_status, rd_access, busy, start;
  logic [31:0] status_word;

  logic clk_lvl, clk_fall, data_lvl, data_fall_unused;
  logic phase_timeout;
  logic unused_inputs;

  ps2_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clk (
    .clk_i   (clk_i),
    .reset_n (reset_n),
    .din     (ps2_clk_i),
    .level   (clk_lvl),
    .fall    (clk_fall)
  );

  ps2_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_data (
    .clk_i   (clk_i),
    .reset_n (reset_n),
    .din     (ps2_data_i),
    .level   (data_lvl),
    .fall    (data_fall_unused)
  );

  assign unused_inputs = &{1'b0, sel_i[3:1], dat_i[31:8], data_fall_unused};

  // Bus decode: an access takes effect in the single cycle its ack is issued.
  always_comb begin
    busy      = (state_q != S_IDLE);
    access    = cyc_i & stb_i & ~acked_q;
    wr_data   = access & we_i & (adr_i == REG_DATA);
    wr_status = access & we_i & (adr_i == REG_STATUS);
    rd_access = access & ~we_i;
    start     = wr_data & sel_i[0] & ~busy;
    clr       = wr_status ? dat_i[ST_OVERRUN:ST_DONE] : '0;

    status_word             = '0;
    status_word[ST_BUSY]    = busy;
    status_word[ST_DONE]    = done_q;
    status_word[ST_NACK]    = nack_q;
    status_word[ST_TIMEOUT] = timeout_q;
    status_word[ST_OVERRUN] = overrun_q;
  end

  // acked_q stays set until the strobe drops, so a long strobe yields one ack.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      ack_o   <= 1'b0;
      acked_q <= 1'b0;
      dat_q   <= '0;
    end else begin
      if (!(cyc_i && stb_i)) begin
        ack_o   <= 1'b0;
        acked_q <= 1'b0;
      end else begin
        ack_o   <= ~acked_q;
        acked_q <= 1'b1;
      end
      if (rd_access) begin
        dat_q <= (adr_i == REG_STATUS) ? status_word : {24'h0, data_q};
      end
    end
  end

  assign dat_o = dat_q;

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      data_q   <= '0;
      parity_q <= 1'b0;
    end else if (start) begin
      data_q   <= dat_i[7:0];
      parity_q <= odd_parity(dat_i[7:0]);
    end
  end

  // Hardware set wins over a same-cycle write-1-to-clear.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      done_q    <= 1'b0;
      nack_q    <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      done_q    <= (done_q    & ~clr[0]) | set_done;
      nack_q    <= (nack_q    & ~clr[1]) | set_nack;
      timeout_q <= (timeout_q & ~clr[2]) | set_timeout;
      overrun_q <= (overrun_q & ~clr[3]) | (wr_data & busy);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Frame bits presented on successive device falling edges; bit 9 is stop.
  assign frame         = {1'b1, parity_q, data_q};
  assign phase_timeout = (cnt_q == TMO_LAST);

  // Line drives decode directly from registered state so that the
  // asynchronous reset releases both lines immediately.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    set_done    = 1'b0;
    set_nack    = 1'b0;
    set_timeout = 1'b0;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_INHIBIT;
      end
      S_INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (cnt_q == INH_LAST) begin
          ps2_data_oe = 1'b1;
          state_d     = S_REQUEST;
        end
      end
      S_REQUEST: begin
        ps2_data_oe = 1'b1;
        if (clk_fall) begin
          state_d = S_SHIFT;
          idx_d   = '0;
        end else if (phase_timeout) begin
          state_d     = S_IDLE;
          set_timeout = 1'b1;
        end
      end
      S_SHIFT: begin
        ps2_data_oe = ~frame[idx_q];
        if (clk_fall) begin
          if (idx_q == 4'd8) state_d = S_ACK;
          else               idx_d   = idx_q + 4'd1;
        end else if (phase_timeout) begin
          state_d     = S_IDLE;
          set_timeout = 1'b1;
        end
      end
      S_ACK: begin
        if (clk_fall) begin
          state_d  = S_RELEASE;
          set_done = ~data_lvl;
          set_nack = data_lvl;
        end else if (phase_timeout) begin
          state_d     = S_IDLE;
          set_timeout = 1'b1;
        end
      end
      S_RELEASE: begin
        if (clk_lvl && data_lvl) begin
          state_d = S_IDLE;
        end else if (phase_timeout) begin
          state_d     = S_IDLE;
          set_timeout = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The fall caused by our own inhibit pull is not a device edge and must
    // not stretch the inhibit time.
    if (state_d != state_q || state_q == S_IDLE ||
        (clk_fall && state_q != S_INHIBIT)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

`ifdef PS2_HOST_TX_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) irq_q <= 1'b0;
    else          irq_q <= done_q | nack_q | timeout_q;
  end

  assign interrupt = irq_q;
`else
  assign interrupt = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int unsigned INH  = 20;
  localparam int unsigned TMO  = 300;
  localparam int unsigned HALF = 10;
`ifdef PS2_HOST_TX_IRQ_EN
  localparam logic IRQ_EN = 1'b1;
`else
  localparam logic IRQ_EN = 1'b0;
`endif

  logic        clk_i   = 1'b0;
  logic        reset_n = 1'b0;
  logic        cyc_i   = 1'b0;
  logic        stb_i   = 1'b0;
  logic        we_i    = 1'b0;
  logic        adr_i   = 1'b0;
  logic [3:0]  sel_i   = '0;
  logic [31:0] dat_i   = '0;
  logic [31:0] dat_o;
  logic        ack_o;
  logic        ps2_clk_i, ps2_data_i, ps2_clk_oe, ps2_data_oe, interrupt;
  logic        dev_clk  = 1'b1;
  logic        dev_data = 1'b1;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] exp_rd[$];
  logic        exp_bits[$];

  int unsigned inh_run = 0, inh_both = 0, inh_last = 0, inh_both_last = 0;

  // Open-drain wired-AND of host and device drivers.
  assign ps2_clk_i  = ~ps2_clk_oe  & dev_clk;
  assign ps2_data_i = ~ps2_data_oe & dev_data;

  always #5 clk_i = ~clk_i;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO),
    .SYNC_STAGES    (2)
  ) dut (
    .clk_i       (clk_i),
    .reset_n     (reset_n),
    .cyc_i       (cyc_i),
    .stb_i       (stb_i),
    .we_i        (we_i),
    .adr_i       (adr_i),
    .sel_i       (sel_i),
    .dat_i       (dat_i),
    .dat_o       (dat_o),
    .ack_o       (ack_o),
    .ps2_clk_i   (ps2_clk_i),
    .ps2_data_i  (ps2_data_i),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .interrupt   (interrupt)
  );

  // Measures each inhibit pulse and how many of its cycles also drive data.
  always @(negedge clk_i) begin
    if (ps2_clk_oe) begin
      inh_run  <= inh_run + 1;
      inh_both <= inh_both + (ps2_data_oe ? 1 : 0);
    end else if (inh_run != 0) begin
      inh_last      <= inh_run;
      inh_both_last <= inh_both;
      inh_run       <= 0;
      inh_both      <= 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic wb_cycle(input logic we, input logic adr, input logic [31:0] wd,
                          input int unsigned hold, output logic [31:0] rd);
    int unsigned acks  = 0;
    int unsigned first = 0;
    rd = '0;
    @(posedge clk_i); #1;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; sel_i = 4'hF; dat_i = wd;
    for (int unsigned n = 0; n < hold + 2; n++) begin
      @(negedge clk_i);
      if (ack_o) begin
        if (acks == 0) begin
          first = n;
          rd    = dat_o;
        end
        acks++;
      end
    end
    @(posedge clk_i); #1;
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    check("ack_count", acks, 1);
    check("ack_latency", first, 1);
  endtask

  task automatic wb_write(input logic adr, input logic [31:0] wd, input int unsigned hold);
    logic [31:0] dummy;
    wb_cycle(1'b1, adr, wd, hold, dummy);
  endtask

  task automatic wb_read(input logic adr, input logic [31:0] exp, input string name,
                         input int unsigned hold);
    logic [31:0] rd;
    exp_rd.push_back(exp);
    wb_cycle(1'b0, adr, '0, hold, rd);
    check(name, rd, exp_rd.pop_front());
  endtask

  task automatic push_frame(input logic [7:0] b);
    exp_bits.push_back(1'b0);
    for (int unsigned i = 0; i < 8; i++) exp_bits.push_back(b[i]);
    exp_bits.push_back(~(^b));
    exp_bits.push_back(1'b1);
  endtask

  task automatic sample_bit(input int unsigned k);
    if (exp_bits.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL line_bit%0d: actual %b required none (queue empty)", k, ps2_data_i);
    end else begin
      check($sformatf("line_bit%0d", k), {31'b0, ps2_data_i}, {31'b0, exp_bits.pop_front()});
    end
  endtask

  task automatic wait_request();
    int unsigned w = 0;
    while (!(!ps2_clk_oe && ps2_data_oe) && w < 500) begin
      @(negedge clk_i);
      w++;
    end
    check("request_seen", {31'b0, ~ps2_clk_oe & ps2_data_oe}, 32'd1);
  endtask

  // Device side: 11 clock pulses; samples data on each rising edge, drives
  // ack_bit on the data line before the 11th falling edge.
  task automatic device_frame(input logic ack_bit);
    wait_request();
    sample_bit(0);
    for (int unsigned i = 0; i < 11; i++) begin
      repeat (HALF) @(negedge clk_i);
      if (i == 10) dev_data = ack_bit;
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk_i);
      dev_clk = 1'b1;
      if (i < 10) sample_bit(i + 1);
    end
    dev_data = 1'b1;
  endtask

  typedef struct {
    logic [7:0]  b;
    logic        ack_bit;
    int unsigned hold;
    logic [31:0] exp_status;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'hF4, 1'b0, 0, 32'h02};
    vecs[1] = '{8'hFF, 1'b1, 3, 32'h04};
    vecs[2] = '{8'h00, 1'b0, 1, 32'h02};
    vecs[3] = '{8'hA5, 1'b1, 7, 32'h04};
    vecs[4] = '{8'h01, 1'b0, 2, 32'h02};

    // Reset state.
    repeat (3) @(negedge clk_i);
    check("rst_clk_oe", {31'b0, ps2_clk_oe}, 0);
    check("rst_data_oe", {31'b0, ps2_data_oe}, 0);
    check("rst_ack", {31'b0, ack_o}, 0);
    check("rst_dat_o", dat_o, 0);
    check("rst_irq", {31'b0, interrupt}, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_i);
    wb_read(1'b1, 32'h0, "rst_status", 0);
    wb_read(1'b0, 32'h0, "rst_data", 0);

    // Complete frames with ACK / NACK from the device model.
    for (int i = 0; i < 5; i++) begin
      push_frame(vecs[i].b);
      wb_write(1'b0, {24'h0, vecs[i].b}, vecs[i].hold);
      device_frame(vecs[i].ack_bit);
      repeat (10) @(negedge clk_i);
      check("inhibit_len", inh_last, INH);
      check("start_bit_cycles", inh_both_last, 1);
      check("bits_consumed", exp_bits.size(), 0);
      wb_read(1'b1, vecs[i].exp_status, "status", vecs[i].hold);
      wb_read(1'b0, {24'h0, vecs[i].b}, "data_reg", 0);
      check("irq_set", {31'b0, interrupt}, {31'b0, IRQ_EN});
      wb_write(1'b1, 32'h1E, 0);
      wb_read(1'b1, 32'h0, "status_cleared", 0);
      check("irq_cleared", {31'b0, interrupt}, 0);
    end

    // Device never clocks: request phase times out.
    wb_write(1'b0, 32'hED, 0);
    repeat (INH + TMO / 2) @(negedge clk_i);
    check("to_hold_clk_oe", {31'b0, ps2_clk_oe}, 0);
    check("to_hold_data_oe", {31'b0, ps2_data_oe}, 1);
    repeat (TMO / 2 + 20) @(negedge clk_i);
    check("to_clk_oe", {31'b0, ps2_clk_oe}, 0);
    check("to_data_oe", {31'b0, ps2_data_oe}, 0);
    wb_read(1'b1, 32'h08, "to_status", 0);
    check("to_irq", {31'b0, interrupt}, {31'b0, IRQ_EN});
    wb_write(1'b1, 32'h1E, 0);
    wb_read(1'b1, 32'h0, "to_cleared", 0);

    // Second DATA write mid-SHIFT is dropped and flags OVERRUN.
    push_frame(8'h3C);
    wb_write(1'b0, 32'h3C, 0);
    fork
      device_frame(1'b0);
      begin
        repeat (INH + HALF * 5) @(negedge clk_i);
        wb_write(1'b0, 32'h55, 0);
      end
    join
    repeat (10) @(negedge clk_i);
    check("ovr_bits_consumed", exp_bits.size(), 0);
    wb_read(1'b0, 32'h3C, "ovr_data", 0);
    wb_read(1'b1, 32'h12, "ovr_status", 0);
    wb_write(1'b1, 32'h1E, 0);
    wb_read(1'b1, 32'h0, "ovr_cleared", 0);

    // Asynchronous reset in the middle of SHIFT.
    wb_write(1'b0, 32'h00, 0);
    wait_request();
    repeat (HALF) @(negedge clk_i);
    dev_clk = 1'b0;
    repeat (HALF) @(negedge clk_i);
    check("pre_rst_data_oe", {31'b0, ps2_data_oe}, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_clk_oe", {31'b0, ps2_clk_oe}, 0);
    check("mid_rst_data_oe", {31'b0, ps2_data_oe}, 0);
    check("mid_rst_dat_o", dat_o, 0);
    dev_clk = 1'b1;
    repeat (3) @(negedge clk_i);
    reset_n = 1'b1;
    repeat (3) @(negedge clk_i);
    wb_read(1'b1, 32'h0, "post_rst_status", 0);
    wb_read(1'b0, 32'h0, "post_rst_data", 0);

    // One ack per access regardless of strobe length.
    for (int unsigned h = 0; h < 10; h += 3) begin
      wb_read(1'b1, 32'h0, "ack_hold_status", h);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
